mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 mem_arbiter SHALL arbitrate four cache requesters (0=I-cache PID0, 1=I-cache PID1, 2=D-cache PID0, 3=D-cache PID1) onto the single slowmem port.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req  input  4  per-requester request; held high until that requester's done pulse.
REQ-005 req_rnotw  input  4  per-requester direction: 1 = read, 0 = write.
REQ-006 req_addr  input  64  four 16-bit addresses; requester i at bits [16i+15:16i].
REQ-007 req_wdata  input  64  four 16-bit write words, same packing as req_addr.
REQ-008 gnt  output  4  one-hot; the requester currently owning the memory port, else 0.
REQ-009 done  output  4  one-hot, one-cycle pulse; the granted transaction has completed.
REQ-010 rdata  output  16  read data; valid only in the cycle done is high for a read.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 m_strobe, m_rnotw  output  1 each  slowmem strobe and direction.
REQ-013 m_addr, m_wdata  output  16 each  slowmem address and write data.
REQ-014 m_mfc  input  1  slowmem fetch-complete pulse; m_rdata (input, 16) valid while m_mfc is high.

Function
REQ-015 All outputs SHALL be registered; states SHALL be IDLE, ISSUE and WAIT.
REQ-016 In IDLE, if any unmasked req bit is high, the arbiter SHALL latch the winner index, its rnotw, addr and wdata, set gnt, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 In ISSUE, m_strobe SHALL be high for exactly one cycle with m_rnotw, m_addr and m_wdata from the latched values.
REQ-018 After a write ISSUE, the arbiter SHALL pulse done for the winner on the next cycle, clear gnt and return to IDLE (write latency 2 cycles from grant).
REQ-019 After a read ISSUE, the arbiter SHALL enter WAIT with m_strobe low.
REQ-020 In WAIT, on m_mfc=1 it SHALL register m_rdata into rdata, pulse done for the winner next cycle, clear gnt and return to IDLE.
REQ-021 With MEMDELAY=4, grant-to-done latency for a read SHALL be 7 cycles.
REQ-022 m_mfc SHALL be ignored in IDLE and ISSUE.
REQ-023 In the IDLE cycle coincident with a done pulse, the just-served requester SHALL be masked from arbitration, so a late-falling req is not re-granted.
REQ-024 The arbiter SHALL never assert m_strobe in two consecutive cycles, and SHALL never issue a new request while a read is in WAIT.
REQ-025 A requester that drops req before it is granted SHALL simply not be granted; a requester that drops req after it is granted SHALL still see its transaction complete.
REQ-026 gnt, done and m_strobe SHALL each be at most one-hot.

Reset
REQ-027 On reset: state=IDLE; gnt, done, m_strobe, busy and rdata = 0; m_rnotw=1; m_addr, m_wdata = 0; priority pointer = 0; mask cleared.
REQ-028 Reset asserted during ISSUE or WAIT SHALL abandon the transaction with no done pulse; a subsequent stray m_mfc SHALL be ignored per REQ-022.

Configuration
REQ-029 Macro MEMARB_ROUNDROBIN_EN defined: the winner SHALL be the first requesting index at or after the pointer, modulo 4; after each grant, the pointer SHALL be set to winner+1 mod 4.
REQ-030 Macro MEMARB_ROUNDROBIN_EN undefined: fixed priority, lowest index wins; the pointer SHALL be absent.

Verification
REQ-031 Single write, req=0001, addr 0x0010, wdata 0xBEEF -> m_strobe one cycle with m_rnotw=0; done=0001 two cycles after gnt; slowmem m[0x0010]=0xBEEF.
REQ-032 Single read by requester 2 of preloaded m[0x8000]=0x1234 -> gnt=0100; done=0100 7 cycles later; rdata=0x1234 in that same cycle.
REQ-033 req=1111 held, reads throughout, with round-robin enabled -> grant order 0,1,2,3,0; without the macro -> requester 0 is granted every time after its mask cycle.
REQ-034 Read in WAIT while requester 1 raises req -> no m_strobe until done; requester 1 is granted in the following IDLE cycle.
REQ-035 Reset pulsed during WAIT -> all outputs return to their reset values; stray m_mfc produces no done; the next read completes correctly.

Source files
------------

// File: rtl/mem_arbiter.sv
// Four-requester arbiter for the shared slowmem port (IDLE -> ISSUE -> [WAIT] -> IDLE).
// Define MEMARB_ROUNDROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  req_rnotw,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        m_strobe,
    output logic        m_rnotw,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic        m_mfc,
    input  logic [15:0] m_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]  state;
    logic [3:0]  mask;
    logic [3:0]  cand;
    logic [1:0]  win;
    logic [15:0] win_addr;
    logic [15:0] win_wdata;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // The requester served in the previous cycle is masked so a late-falling req is not re-granted.
    assign cand = req & ~mask;

`ifdef MEMARB_ROUNDROBIN_EN
    logic [1:0] ptr;
    logic [3:0] rot;

    // rot[j] is the candidate at position (ptr + j) mod 4.
    always_comb begin
        rot = cand;
        case (ptr)
            2'd1:    rot = {cand[0],   cand[3:1]};
            2'd2:    rot = {cand[1:0], cand[3:2]};
            2'd3:    rot = {cand[2:0], cand[3]};
            default: rot = cand;
        endcase
    end

    assign win = ptr + first_set(rot);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (state == IDLE && cand != 4'b0000) begin
            ptr <= win + 2'd1;
        end
    end
`else
    assign win = first_set(cand);
`endif

    assign win_addr  = req_addr[{win, 4'b0000} +: 16];
    assign win_wdata = req_wdata[{win, 4'b0000} +: 16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            done     <= 4'b0000;
            mask     <= 4'b0000;
            m_strobe <= 1'b0;
            m_rnotw  <= 1'b1;
            m_addr   <= 16'h0000;
            m_wdata  <= 16'h0000;
            rdata    <= 16'h0000;
            busy     <= 1'b0;
        end else begin
            done     <= 4'b0000;
            mask     <= 4'b0000;
            m_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != 4'b0000) begin
                        gnt      <= 4'b0001 << win;
                        m_strobe <= 1'b1;
                        m_rnotw  <= req_rnotw[win];
                        m_addr   <= win_addr;
                        m_wdata  <= win_wdata;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // m_rnotw still holds the latched direction of the granted transaction.
                    if (m_rnotw) begin
                        state <= WAIT;
                    end else begin
                        done  <= gnt;
                        mask  <= gnt;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (m_mfc) begin
                        rdata <= m_rdata;
                        done  <= gnt;
                        mask  <= gnt;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a slowmem model (MEMDELAY=4) and a transaction-level reference.
// Latencies are counted from the IDLE cycle in which the winner is chosen; gnt becomes visible one cycle later.
module tb_mem_arbiter;

    localparam int MEMDELAY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_rnotw;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] rdata;
    logic        busy;
    logic        m_strobe;
    logic        m_rnotw;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_mfc;
    logic [15:0] m_rdata = 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] smem [0:65535];
    logic        mem_mfc = 1'b0;
    logic        stray_mfc = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = 16'h0000;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rnotw (req_rnotw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .m_strobe  (m_strobe),
        .m_rnotw   (m_rnotw),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_mfc     (m_mfc),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slowmem: writes land on the strobe edge; a read answers with a one-cycle mfc
    // MEMDELAY+1 cycles after its strobe cycle.
    assign m_mfc = mem_mfc | stray_mfc;
    always @(posedge clk) begin
        mem_mfc <= 1'b0;
        if (pend) begin
            if (cnt == 1) begin
                mem_mfc <= 1'b1;
                m_rdata <= smem[paddr];
                pend    <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (m_strobe) begin
            if (m_rnotw) begin
                pend  <= 1'b1;
                cnt   <= MEMDELAY;
                paddr <= m_addr;
            end else begin
                smem[m_addr] = m_wdata;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
        vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL rst_done: got %b expected 0000", done); end
        vectors++; if (m_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_strobe: got %b expected 0", m_strobe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (rdata !== 16'h0000) begin miscompares++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
        vectors++; if (m_rnotw !== 1'b1) begin miscompares++; $display("FAIL rst_rnotw: got %b expected 1", m_rnotw); end
        vectors++; if (m_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr: got %h expected 0000", m_addr); end
        vectors++; if (m_wdata !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata: got %h expected 0000", m_wdata); end
        @(negedge clk);
        vectors++; if (gnt !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_noreq: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
    endtask

    task automatic test_single_write();
        do_reset();
        req = 4'b0001; req_rnotw = 4'b0000;
        req_addr[15:0] = 16'h0010; req_wdata[15:0] = 16'hBEEF;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wr_gnt: got %b expected 0001", gnt); end
        vectors++; if (m_strobe !== 1'b1 || m_rnotw !== 1'b0) begin miscompares++; $display("FAIL wr_strobe: got strobe=%b rnotw=%b expected 1/0", m_strobe, m_rnotw); end
        vectors++; if (m_addr !== 16'h0010 || m_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL wr_bus: got %h/%h expected 0010/beef", m_addr, m_wdata); end
        @(negedge clk);
        vectors++; if (done !== 4'b0001 || gnt !== 4'b0000) begin miscompares++; $display("FAIL wr_done: got done=%b gnt=%b expected 0001/0000", done, gnt); end
        vectors++; if (m_strobe !== 1'b0) begin miscompares++; $display("FAIL wr_strobe_once: got %b expected 0", m_strobe); end
        @(negedge clk);
        req = 4'b0000;
        vectors++; if (gnt !== 4'b0000 || done !== 4'b0000) begin miscompares++; $display("FAIL wr_mask: got gnt=%b done=%b expected 0000/0000", gnt, done); end
        vectors++; if (smem[16'h0010] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_mem: got %h expected beef", smem[16'h0010]); end
    endtask

    task automatic test_single_read();
        do_reset();
        req = 4'b0100; req_rnotw = 4'b0100; req_addr[47:32] = 16'h8000;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL rd_gnt: got %b expected 0100", gnt); end
        vectors++; if (m_strobe !== 1'b1 || m_rnotw !== 1'b1 || m_addr !== 16'h8000) begin miscompares++; $display("FAIL rd_issue: got strobe=%b rnotw=%b addr=%h expected 1/1/8000", m_strobe, m_rnotw, m_addr); end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            vectors++; if (done !== 4'b0000 || m_strobe !== 1'b0 || gnt !== 4'b0100 || busy !== 1'b1) begin miscompares++; $display("FAIL rd_wait%0d: got done=%b strobe=%b gnt=%b busy=%b expected 0000/0/0100/1", k, done, m_strobe, gnt, busy); end
        end
        @(negedge clk);
        vectors++; if (done !== 4'b0100) begin miscompares++; $display("FAIL rd_done: got %b expected 0100", done); end
        vectors++; if (rdata !== 16'h1234) begin miscompares++; $display("FAIL rd_data: got %h expected 1234", rdata); end
        @(negedge clk);
        req = 4'b0000;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rd_mask: got %b expected 0000", gnt); end
    endtask

    task automatic test_all_requesters();
        int exp_order [5];
        int n = 0;
        int budget = 200;
        logic [3:0] prev_gnt = 4'b0000;
`ifdef MEMARB_ROUNDROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        req = 4'b1111; req_rnotw = 4'b1111;
        req_addr = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
        while (n < 5 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                vectors++; if (gnt !== (4'b0001 << exp_order[n])) begin miscompares++; $display("FAIL order%0d: got %b expected requester %0d", n, gnt, exp_order[n]); end
                n++;
            end
            prev_gnt = gnt;
        end
        if (n < 5) begin vectors++; miscompares++; $display("FAIL order_timeout: got %0d grants expected 5", n); end
        req = 4'b0000;
        budget = 20;
        while (busy !== 1'b0 && budget > 0) begin @(negedge clk); budget--; end
        @(negedge clk);
    endtask

    task automatic test_wait_blocking();
        do_reset();
        req = 4'b0001; req_rnotw = 4'b0001; req_addr[15:0] = 16'h0020;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0001 || m_strobe !== 1'b1) begin miscompares++; $display("FAIL wb_gnt0: got gnt=%b strobe=%b expected 0001/1", gnt, m_strobe); end
        req[1] = 1'b1; req_rnotw[1] = 1'b0; req_addr[31:16] = 16'h0040; req_wdata[31:16] = 16'hCAFE;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            vectors++; if (m_strobe !== 1'b0 || gnt !== 4'b0001 || done !== 4'b0000) begin miscompares++; $display("FAIL wb_wait%0d: got strobe=%b gnt=%b done=%b expected 0/0001/0000", k, m_strobe, gnt, done); end
        end
        @(negedge clk);
        vectors++; if (done !== 4'b0001 || rdata !== 16'h5A5A) begin miscompares++; $display("FAIL wb_done0: got done=%b rdata=%h expected 0001/5a5a", done, rdata); end
        req[0] = 1'b0;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0010 || m_strobe !== 1'b1 || m_rnotw !== 1'b0 || m_addr !== 16'h0040) begin miscompares++; $display("FAIL wb_gnt1: got gnt=%b strobe=%b rnotw=%b addr=%h expected 0010/1/0/0040", gnt, m_strobe, m_rnotw, m_addr); end
        @(negedge clk);
        vectors++; if (done !== 4'b0010) begin miscompares++; $display("FAIL wb_done1: got %b expected 0010", done); end
        @(negedge clk);
        req[1] = 1'b0;
        vectors++; if (smem[16'h0040] !== 16'hCAFE) begin miscompares++; $display("FAIL wb_mem: got %h expected cafe", smem[16'h0040]); end
    endtask

    task automatic test_reset_in_wait();
        // Starts idle with rdata still holding the previous read (5a5a), so its clearing is observable.
        req = 4'b1000; req_rnotw = 4'b1000; req_addr[63:48] = 16'h0030;
        @(negedge clk);
        vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL rw_gnt: got %b expected 1000", gnt); end
        @(negedge clk);
        reset = 1'b1; req = 4'b0000;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0000 || done !== 4'b0000 || m_strobe !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rw_ctrl: got gnt=%b done=%b strobe=%b busy=%b expected all 0", gnt, done, m_strobe, busy); end
        vectors++; if (rdata !== 16'h0000 || m_rnotw !== 1'b1 || m_addr !== 16'h0000 || m_wdata !== 16'h0000) begin miscompares++; $display("FAIL rw_data: got rdata=%h rnotw=%b addr=%h wdata=%h expected 0000/1/0000/0000", rdata, m_rnotw, m_addr, m_wdata); end
        reset = 1'b0; stray_mfc = 1'b1;
        @(negedge clk);
        stray_mfc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vectors++; if (done !== 4'b0000 || gnt !== 4'b0000) begin miscompares++; $display("FAIL rw_stray%0d: got done=%b gnt=%b expected 0000/0000", k, done, gnt); end
            @(negedge clk);
        end
        req = 4'b0100; req_rnotw = 4'b0100; req_addr[47:32] = 16'h8000;
        @(negedge clk);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL rw_regnt: got %b expected 0100", gnt); end
        repeat (6) @(negedge clk);
        vectors++; if (done !== 4'b0100 || rdata !== 16'h1234) begin miscompares++; $display("FAIL rw_reread: got done=%b rdata=%h expected 0100/1234", done, rdata); end
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_random();
        int st [4];
        logic [15:0] model_mem [16];
        logic [3:0]  mmask, cand, exp_gnt, exp_done;
        logic        exp_strobe, cur_read, model_free;
        logic [15:0] cur_addr, cur_wdata, exp_rdata;
        int cur, arb_cyc, done_cyc, ptr, w;
        for (int k = 0; k < 16; k++) begin
            model_mem[k] = 16'($urandom);
            smem[16'h0100 + 16'(k)] = model_mem[k];
        end
        do_reset();
        st = '{0, 0, 0, 0};
        mmask = 4'b0000; model_free = 1'b1; ptr = 0; cur = 0;
        arb_cyc = 0; done_cyc = 0; cur_read = 1'b0;
        cur_addr = 16'h0000; cur_wdata = 16'h0000; exp_rdata = 16'h0000;
        for (int n = 0; n < 800; n++) begin
            exp_gnt    = (!model_free && cyc > arb_cyc && cyc < done_cyc) ? (4'b0001 << cur) : 4'b0000;
            exp_done   = (!model_free && cyc == done_cyc) ? (4'b0001 << cur) : 4'b0000;
            exp_strobe = !model_free && (cyc == arb_cyc + 1);
            vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, gnt, exp_gnt); end
            vectors++; if (done !== exp_done) begin miscompares++; $display("FAIL rnd_done@%0d: got %b expected %b", cyc, done, exp_done); end
            vectors++; if (m_strobe !== exp_strobe) begin miscompares++; $display("FAIL rnd_strobe@%0d: got %b expected %b", cyc, m_strobe, exp_strobe); end
            vectors++; if (busy !== (exp_gnt != 4'b0000)) begin miscompares++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, exp_gnt != 4'b0000); end
            if (exp_strobe) begin
                vectors++; if (m_rnotw !== cur_read || m_addr !== cur_addr || m_wdata !== cur_wdata) begin miscompares++; $display("FAIL rnd_bus@%0d: got %b/%h/%h expected %b/%h/%h", cyc, m_rnotw, m_addr, m_wdata, cur_read, cur_addr, cur_wdata); end
            end
            if (exp_done != 4'b0000) begin
                if (cur_read) begin
                    vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata@%0d: got %h expected %h", cyc, rdata, exp_rdata); end
                end
                model_free = 1'b1;
                st[cur] = 3;
            end
            mmask = exp_done;
            for (int i = 0; i < 4; i++) begin
                case (st[i])
                    0: if ($urandom_range(3) == 0) begin
                        st[i] = 1; req[i] = 1'b1; req_rnotw[i] = 1'($urandom_range(1));
                        req_addr[16*i +: 16]  = 16'h0100 + 16'($urandom_range(15));
                        req_wdata[16*i +: 16] = 16'($urandom);
                    end
                    1: if ($urandom_range(15) == 0) begin st[i] = 0; req[i] = 1'b0; end
                    2: if ($urandom_range(7) == 0) req[i] = 1'b0;
                    default: begin st[i] = 0; req[i] = 1'b0; end
                endcase
            end
            if (model_free) begin
                cand = req & ~mmask;
                if (cand != 4'b0000) begin
                    w = -1;
                    for (int k = 0; k < 4; k++) if (w < 0 && cand[(ptr + k) % 4]) w = (ptr + k) % 4;
                    cur = w; arb_cyc = cyc; st[w] = 2; model_free = 1'b0;
                    cur_read  = req_rnotw[w];
                    cur_addr  = req_addr[16*w +: 16];
                    cur_wdata = req_wdata[16*w +: 16];
                    done_cyc  = cyc + (cur_read ? 7 : 2);
                    if (cur_read) exp_rdata = model_mem[cur_addr[3:0]];
                    else model_mem[cur_addr[3:0]] = cur_wdata;
`ifdef MEMARB_ROUNDROBIN_EN
                    ptr = (w + 1) % 4;
`endif
                end
            end
            @(negedge clk);
        end
        req = 4'b0000;
    endtask

    initial begin
        reset = 1'b1;
        req = 4'b0000; req_rnotw = 4'b0000;
        req_addr = 64'h0; req_wdata = 64'h0;
        for (int a = 0; a < 65536; a++) smem[a] = 16'h0000;
        smem[16'h8000] = 16'h1234;
        smem[16'h0020] = 16'h5A5A;
        smem[16'h0030] = 16'h7777;
        test_reset();
        test_single_write();
        test_single_read();
        test_all_requesters();
        test_wait_blocking();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
